// File: rtl/retire_recovery_ctrl_if.sv
// Retire-stage recovery/halt request bundle and sequencer outputs.
// Perf counter signals exist only when RECOVERY_PERF_CNT_EN is defined.
interface retire_recovery_ctrl_if #(
    parameter int ARCH_REGS = 32,
    parameter int XLEN_W    = 32
);
    localparam int BW = (ARCH_REGS > 1) ? $clog2(ARCH_REGS) : 1;

    logic              recover_req;
    logic [XLEN_W-1:0] recover_pc;
    logic              halt_req;
    logic              sq_empty;
    logic              retire_block;
    logic              stall_dispatch;
    logic              squash;
    logic              copy_en;
    logic [BW-1:0]     copy_base;
    logic              fl_rebuild;
    logic              redirect_valid;
    logic [XLEN_W-1:0] redirect_pc;
    logic              halt;
`ifdef RECOVERY_PERF_CNT_EN
    logic [31:0]       recover_count;
    logic [31:0]       stall_cycles;
`endif

    modport master (
        output recover_req, recover_pc, halt_req, sq_empty,
        input  retire_block, stall_dispatch, squash, copy_en, copy_base,
        input  fl_rebuild, redirect_valid, redirect_pc, halt
`ifdef RECOVERY_PERF_CNT_EN
        , input recover_count, stall_cycles
`endif
    );

    modport slave (
        input  recover_req, recover_pc, halt_req, sq_empty,
        output retire_block, stall_dispatch, squash, copy_en, copy_base,
        output fl_rebuild, redirect_valid, redirect_pc, halt
`ifdef RECOVERY_PERF_CNT_EN
        , output recover_count, stall_cycles
`endif
    );
endinterface

// File: rtl/retire_recovery_ctrl.sv
// Retire recovery/halt sequencer: squash, map copy, FL rebuild, redirect.
// Optional perf counters enabled by defining RECOVERY_PERF_CNT_EN.
module retire_recovery_ctrl #(
    parameter int ARCH_REGS  = 32,
    parameter int COPY_LANES = 8,
    parameter int XLEN_W     = 32
) (
    input logic clock,
    input logic reset,
    retire_recovery_ctrl_if.slave rif
);
    localparam int GROUPS = ARCH_REGS / COPY_LANES;
    localparam int CW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int BW = (ARCH_REGS > 1) ? $clog2(ARCH_REGS) : 1;
    localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);
    localparam logic [BW-1:0] STEP = BW'(COPY_LANES);

    typedef enum logic [2:0] {
        IDLE, SQUASH, COPY, FLREBUILD, REDIRECT, DRAIN, HALTED
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     base_q;
    logic [XLEN_W-1:0] pc_q;
    logic              squash_q;
    logic              copy_q;
    logic              fl_q;
    logic              rv_q;
    logic              halt_q;
    logic              stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            base_q   <= '0;
            pc_q     <= '0;
            squash_q <= 1'b0;
            copy_q   <= 1'b0;
            fl_q     <= 1'b0;
            rv_q     <= 1'b0;
            halt_q   <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            squash_q <= 1'b0;
            copy_q   <= 1'b0;
            fl_q     <= 1'b0;
            rv_q     <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Recovery wins: a same-cycle halt sits on the squashed path.
                    if (rif.recover_req) begin
                        pc_q     <= rif.recover_pc;
                        state    <= SQUASH;
                        squash_q <= 1'b1;
                        stall_q  <= 1'b1;
                    end else if (rif.halt_req) begin
                        state   <= DRAIN;
                        stall_q <= 1'b1;
                    end
                end
                SQUASH: begin
                    cnt    <= '0;
                    base_q <= '0;
                    copy_q <= 1'b1;
                    state  <= COPY;
                end
                COPY: begin
                    if (cnt == LAST) begin
                        fl_q  <= 1'b1;
                        state <= FLREBUILD;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        base_q <= base_q + STEP;
                        copy_q <= 1'b1;
                    end
                end
                FLREBUILD: begin
                    rv_q  <= 1'b1;
                    state <= REDIRECT;
                end
                REDIRECT: begin
                    stall_q <= 1'b0;
                    state   <= IDLE;
                end
                DRAIN: begin
                    if (rif.sq_empty) begin
                        halt_q <= 1'b1;
                        state  <= HALTED;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Same-cycle block keeps younger ways of the bundle from retiring.
    assign rif.retire_block = stall_q
                            | (state == IDLE &
                               (rif.recover_req | rif.halt_req));
    assign rif.stall_dispatch = stall_q;
    assign rif.squash         = squash_q;
    assign rif.copy_en        = copy_q;
    assign rif.copy_base      = base_q;
    assign rif.fl_rebuild     = fl_q;
    assign rif.redirect_valid = rv_q;
    assign rif.redirect_pc    = pc_q;
    assign rif.halt           = halt_q;

`ifdef RECOVERY_PERF_CNT_EN
    logic [31:0] rec_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            rec_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (state == IDLE && rif.recover_req)
                rec_cnt <= rec_cnt + 32'd1;
            if (stall_q)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign rif.recover_count = rec_cnt;
    assign rif.stall_cycles  = stall_cnt;
`endif
endmodule

// File: doc/retire_recovery_ctrl.md
Name: retire_recovery_ctrl

Overview:
- Sequencer behind the retire stage. Takes the retire stage's branch-recovery request (recover enable plus target PC) and its halt request.
- Walks the core through a fixed recovery sequence: squash, copy the architectural map table back into the rename map table lane by lane, rebuild the free list, then redirect fetch.
- Also sequences halt: waits for the store queue to drain, then raises a sticky halt.
- While any sequence is active it blocks further retirement and stalls dispatch.

Parameters:
- ARCH_REGS, 32, number of architectural registers to restore.
- COPY_LANES, 8, map-table entries restored per cycle; ARCH_REGS must be a multiple of COPY_LANES.
- XLEN_W, 32, PC width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- recover_req  in  1  branch recovery requested by the head retiring entry.
- recover_pc  in  XLEN_W  correct target PC; valid with recover_req.
- halt_req  in  1  a halt instruction is retiring.
- sq_empty  in  1  store queue holds no committed-but-unwritten stores.
- retire_block  out  1  retirement must be suppressed this cycle.
- stall_dispatch  out  1  rename/dispatch must hold.
- squash  out  1  flush all in-flight state (ROB, RS, LSQ, fetch buffer).
- copy_en  out  1  the map table copies lanes copy_base..copy_base+COPY_LANES-1 from the architectural table.
- copy_base  out  $clog2(ARCH_REGS)  first register index of the current copy group.
- fl_rebuild  out  1  free list recomputes its contents from the architectural map table.
- redirect_valid  out  1  fetch loads redirect_pc.
- redirect_pc  out  XLEN_W  captured recovery target.
- halt  out  1  sticky processor halt.

Behaviour:
- States: IDLE, SQUASH, COPY, FLREBUILD, REDIRECT, DRAIN, HALTED. All outputs are registered or decoded from state only; there is no combinational input-to-output path except retire_block.
- Reset (synchronous): state=IDLE, copy counter=0, redirect_pc=0. All outputs are 0 in the cycle after reset is sampled. Reset overrides any in-progress sequence, including HALTED.
- IDLE:
  - recover_req=1: capture recover_pc, go to SQUASH.
  - Otherwise halt_req=1: go to DRAIN.
  - Both asserted in the same cycle: recovery wins and halt_req is dropped. The halt is on the squashed path.
- SQUASH: squash=1 for exactly one cycle. Copy counter cleared. Go to COPY.
- COPY:
  - copy_en=1 and copy_base=counter*COPY_LANES.
  - Lasts ARCH_REGS/COPY_LANES cycles (4 at defaults), with copy_base stepping 0, 8, 16, 24.
  - After the last group, go to FLREBUILD.
- FLREBUILD: fl_rebuild=1 for one cycle. Go to REDIRECT.
- REDIRECT: redirect_valid=1 for one cycle, with redirect_pc held. Go to IDLE.
- Recovery latency: recover_req sampled at cycle 0 gives squash at cycle 1, copy_en at cycles 2–5, fl_rebuild at cycle 6, redirect_valid at cycle 7. IDLE resumes at cycle 8.
- stall_dispatch = 1 in every state except IDLE.
- retire_block:
  - 1 in every non-IDLE state.
  - Also 1 combinationally in IDLE whenever recover_req or halt_req is asserted, so the younger ways in the same retire bundle do not retire.
- recover_req and halt_req asserted while not in IDLE are ignored; the retire stage is already blocked.
- DRAIN:
  - squash=0; stall_dispatch=1.
  - Wait until sq_empty=1, then go to HALTED on the next edge. Zero wait if sq_empty is already high on DRAIN entry: HALTED follows one cycle later.
- HALTED: halt=1; stall_dispatch=1; retire_block=1. Only reset leaves this state.
- Copy counter width is $clog2(ARCH_REGS/COPY_LANES). When COPY_LANES=ARCH_REGS, COPY lasts exactly one cycle with copy_base=0.

Optional Feature:
- Macro: RECOVERY_PERF_CNT_EN.
- Defined:
  - Adds outputs recover_count (32 bits) and stall_cycles (32 bits), both reset to 0.
  - recover_count increments on each SQUASH entry.
  - stall_cycles increments on every cycle with stall_dispatch=1.
  - Both wrap modulo 2^32.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Recovery at defaults: pulse recover_req with recover_pc=32'h80000000 at cycle 0. Expect squash at cycle 1; copy_en at cycles 2–5 with copy_base=0, 8, 16, 24; fl_rebuild at cycle 6; redirect_valid with redirect_pc=32'h80000000 at cycle 7; stall_dispatch high for cycles 1–7 and low at cycle 8.
- Simultaneous requests: recover_req=1 and halt_req=1 in the same IDLE cycle with pc=32'h00001000. Expect the full recovery sequence, halt never asserted, and a return to IDLE.
- Halt with drain: halt_req=1 with sq_empty=0 for 5 cycles, then sq_empty=1. Expect stall_dispatch high throughout, halt=0 until sq_empty rises, halt=1 one cycle later, and halt still 1 after 20 more cycles.
- Busy rejection: during COPY, assert recover_req with pc=32'h00002000. Expect the sequence unaffected and redirect_pc still equal to the first captured PC.
- Reset mid-sequence: assert reset during COPY cycle 3. Expect all outputs 0 on the next cycle and the state back to IDLE; a fresh recover_req then produces a full 7-cycle sequence.
- Perf counters (with RECOVERY_PERF_CNT_EN): two recoveries plus one halt drained in 3 cycles. Expect recover_count=2; stall_cycles=14+4 before HALTED, then incrementing each cycle while HALTED.
